// File: rtl/scan_sequencer.sv
// scan_sequencer: fills line-buffer banks from frame memory and paces row starts to the display driver.
// Define SCAN_SEQUENCER_GAP_EN to hold GAP_CYCLES idle cycles between a finished row and the next issue.
module scan_sequencer #(
   parameter int GAP_CYCLES = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   output logic [10:0] fb_read_address,
   input  logic [47:0] fb_read_data,
   output logic        lb_write_enable,
   output logic [6:0]  lb_write_address,
   output logic [47:0] lb_write_data,
   output logic [4:0]  y,
   output logic [9:0]  frame_count,
   output logic        start,
   input  logic        is_idle,
   output logic        frame_done
);
   typedef enum logic [2:0] {
      IDLE, PREFILL, ISSUE, RUN
`ifdef SCAN_SEQUENCER_GAP_EN
      , GAP
`endif
   } state_t;
   state_t state;
   logic rd_active, fill_bank, busy_seen, fill_idle, run_done, launch, advance;
   logic [4:0] launch_row;
`ifdef SCAN_SEQUENCER_GAP_EN
   logic [7:0] gap_cnt;
`endif
   if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_gap_range
      $error("GAP_CYCLES must be within 1..255");
   end
   assign fill_idle = !rd_active && !lb_write_enable;
   assign run_done = state == RUN && busy_seen && is_idle && fill_idle;
   assign start = state == ISSUE && is_idle;
   assign launch = start || (state == IDLE && enable);
   assign launch_row = state == ISSUE ? y + 5'd1 : 5'd0;
   // RAM data arrives exactly in the write cycle, so it is passed straight through
   assign lb_write_data = lb_write_enable ? fb_read_data : '0;
`ifdef SCAN_SEQUENCER_GAP_EN
   assign advance = state == GAP && gap_cnt == 8'd0;
`else
   assign advance = run_done;
`endif
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         rd_active <= 1'b0;
         fb_read_address <= '0;
         fill_bank <= 1'b0;
         lb_write_enable <= 1'b0;
         lb_write_address <= '0;
      end else begin
         lb_write_enable <= rd_active;
         lb_write_address <= {fill_bank, fb_read_address[5:0]};
         if (launch) begin
            rd_active <= 1'b1;
            fb_read_address <= {launch_row, 6'd0};
            fill_bank <= state == ISSUE && !frame_count[0];
         end else if (rd_active) begin
            rd_active <= fb_read_address[5:0] != 6'd63;
            fb_read_address[5:0] <= fb_read_address[5:0] + 6'd1;
         end
      end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= IDLE;
         y <= '0;
         frame_count <= '0;
         frame_done <= 1'b0;
         busy_seen <= 1'b0;
`ifdef SCAN_SEQUENCER_GAP_EN
         gap_cnt <= '0;
`endif
      end else begin
         frame_done <= 1'b0;
         if (advance) begin
            y <= y + 5'd1;
            frame_count <= frame_count + 10'd1;
            frame_done <= y == 5'd31;
            state <= enable ? ISSUE : IDLE;
         end else
            case (state)
               IDLE: if (enable) begin
                  state <= PREFILL;
                  y <= '0;
                  frame_count <= '0;
               end
               PREFILL: if (fill_idle) state <= ISSUE;
               ISSUE: if (is_idle) begin
                  state <= RUN;
                  busy_seen <= 1'b0;
               end
               RUN: begin
                  if (!is_idle) busy_seen <= 1'b1;
`ifdef SCAN_SEQUENCER_GAP_EN
                  if (run_done) begin
                     state <= GAP;
                     gap_cnt <= 8'(GAP_CYCLES - 1);
                  end
`endif
               end
`ifdef SCAN_SEQUENCER_GAP_EN
               GAP: gap_cnt <= gap_cnt - 8'd1;
`endif
               default: ;
            endcase
      end
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed bench with a synchronous frame-memory model and a fixed-latency driver model.
module tb_scan_sequencer;
`ifdef SCAN_SEQUENCER_GAP_EN
   localparam int GAP = 8;
`else
   localparam int GAP = 0;
`endif
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [10:0] fb_read_address;
   logic [47:0] fb_read_data = '0;
   logic        lb_write_enable;
   logic [6:0]  lb_write_address;
   logic [47:0] lb_write_data;
   logic [4:0]  y;
   logic [9:0]  frame_count;
   logic        start;
   logic        is_idle;
   logic        frame_done;
   logic        hold_busy = 1'b0;
   int busy_len = 140, busy_left = 0, cyc = 0, n_checks = 0, n_err = 0;
   int fd_cnt = 0, bank_viol = 0;
   logic [4:0] fd_y;
   logic [9:0] fd_f;
   logic [6:0]  wr_a[$];
   logic [47:0] wr_d[$];
   logic [4:0]  st_y[$];
   logic [9:0]  st_f[$];
   int          st_c[$];

   scan_sequencer #(.GAP_CYCLES(8)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .fb_read_address(fb_read_address), .fb_read_data(fb_read_data),
      .lb_write_enable(lb_write_enable), .lb_write_address(lb_write_address),
      .lb_write_data(lb_write_data), .y(y), .frame_count(frame_count),
      .start(start), .is_idle(is_idle), .frame_done(frame_done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) fb_read_data <= 48'hA000_0000_0000 | 48'(fb_read_address);
   always @(posedge clock)
      if (start) busy_left <= busy_len;
      else if (busy_left > 0) busy_left <= busy_left - 1;
   assign is_idle = busy_left == 0 && !hold_busy;

   always @(negedge clock) begin
      if (lb_write_enable) begin
         wr_a.push_back(lb_write_address);
         wr_d.push_back(lb_write_data);
         if (!is_idle && lb_write_address[6] == frame_count[0]) bank_viol++;
      end
      if (start) begin
         st_y.push_back(y);
         st_f.push_back(frame_count);
         st_c.push_back(cyc);
      end
      if (frame_done) begin
         fd_cnt++;
         fd_y = y;
         fd_f = frame_count;
      end
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_starts(input int n, input int budget);
      int i = 0;
      while (st_y.size() < n && i < budget) begin
         tick();
         i++;
      end
      chk("start_timeout", 64'(st_y.size() >= n), 64'd1);
   endtask

   function automatic logic [47:0] pat(input int row, input int x);
      logic [10:0] a;
      a = {row[4:0], x[5:0]};
      return 48'hA000_0000_0000 | 48'(a);
   endfunction

   function automatic int count_bad(input int base, input int row, input int bank);
      int bad = 0;
      for (int x = 0; x < 64; x++) begin
         if (base + x >= wr_a.size()) bad++;
         else if (wr_a[base + x] !== {bank[0], x[5:0]} || wr_d[base + x] !== pat(row, x)) bad++;
      end
      return bad;
   endfunction

   initial begin
      int bad, nw, ns, wbase, i;
      repeat (3) tick();
      chk("rst_y", 64'(y), 64'd0);
      chk("rst_fc", 64'(frame_count), 64'd0);
      chk("rst_start", 64'(start), 64'd0);
      chk("rst_fd", 64'(frame_done), 64'd0);
      chk("rst_we", 64'(lb_write_enable), 64'd0);
      chk("rst_wa", 64'(lb_write_address), 64'd0);
      chk("rst_wd", 64'(lb_write_data), 64'd0);
      chk("rst_ra", 64'(fb_read_address), 64'd0);
      reset = 1'b0;
      enable = 1'b1;
      wait_starts(1, 300);
      chk("fill0_count", 64'(wr_a.size()), 64'd64);
      chk("fill0_data", 64'(count_bad(0, 0, 0)), 64'd0);
      chk("start0_y", 64'(st_y[0]), 64'd0);
      chk("start0_fc", 64'(st_f[0]), 64'd0);
      wait_starts(2, 400);
      chk("fill1_count", 64'(wr_a.size()), 64'd128);
      chk("fill1_data", 64'(count_bad(64, 1, 1)), 64'd0);
      chk("start1_y", 64'(st_y[1]), 64'd1);
      chk("start1_fc", 64'(st_f[1]), 64'd1);
      chk("start1_gap", 64'(st_c[1] - st_c[0]), 64'(142 + GAP));
      // driver looks idle for the RUN exit, then reports busy through ISSUE
      i = 0;
      do begin
         tick();
         i++;
      end while (!is_idle && i < 300);
      chk("row1_idle_timeout", 64'(is_idle), 64'd1);
      @(posedge clock);
      #1 hold_busy = 1'b1;
      busy_len = 10;
      repeat (20) tick();
      chk("hold_start", 64'(start), 64'd0);
      chk("hold_count", 64'(st_y.size()), 64'd2);
      @(posedge clock);
      #1 hold_busy = 1'b0;
      tick();
      chk("release_start", 64'(start), 64'd1);
      chk("release_y", 64'(y), 64'd2);
      chk("release_fc", 64'(frame_count), 64'd2);
      i = 0;
      while (fd_cnt == 0 && i < 5000) begin
         tick();
         i++;
      end
      chk("fd_seen", 64'(fd_cnt), 64'd1);
      chk("fd_y", 64'(fd_y), 64'd0);
      chk("fd_fc", 64'(fd_f), 64'd32);
      tick();
      chk("fd_single", 64'(frame_done), 64'd0);
      chk("fd_count", 64'(fd_cnt), 64'd1);
      bad = 0;
      for (int k = 0; k < 32; k++) begin
         if (st_y[k] !== 5'(k) || st_f[k] !== 10'(k)) bad++;
         bad += count_bad(k * 64, k, k % 2);
      end
      chk("frame_rows", 64'(bad), 64'd0);
      i = 0;
      while (!(start && y == 5'd5) && i < 1000) begin
         tick();
         i++;
      end
      chk("row5_start", 64'(start), 64'd1);
      enable = 1'b0;
      repeat (150) tick();
      nw = wr_a.size();
      ns = st_y.size();
      repeat (50) tick();
      chk("stop_writes", 64'(wr_a.size()), 64'(nw));
      chk("stop_starts", 64'(st_y.size()), 64'(ns));
      chk("stop_y", 64'(y), 64'd6);
      chk("stop_fc", 64'(frame_count), 64'd38);
      enable = 1'b1;
      i = 0;
      while (fb_read_address != 11'd30 && i < 100) begin
         tick();
         i++;
      end
      chk("restart_x30", 64'(fb_read_address), 64'd30);
      chk("restart_y", 64'(y), 64'd0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("mid_ra", 64'(fb_read_address), 64'd0);
      chk("mid_we", 64'(lb_write_enable), 64'd0);
      chk("mid_wa", 64'(lb_write_address), 64'd0);
      chk("mid_wd", 64'(lb_write_data), 64'd0);
      chk("mid_y", 64'(y), 64'd0);
      chk("mid_fc", 64'(frame_count), 64'd0);
      chk("mid_start", 64'(start), 64'd0);
      repeat (2) tick();
      wbase = wr_a.size();
      ns = st_y.size();
      reset = 1'b0;
      wait_starts(ns + 1, 300);
      chk("refill_count", 64'(wr_a.size() - wbase), 64'd64);
      chk("refill_data", 64'(count_bad(wbase, 0, 0)), 64'd0);
      chk("refill_y", 64'(st_y[ns]), 64'd0);
      chk("refill_fc", 64'(st_f[ns]), 64'd0);
      chk("bank_safe", 64'(bank_viol), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
